wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback-stage terminus of the 64-bit five-stage pipeline, consuming the MEM/WB pipeline register outputs. Selects writeback data (load data vs. ALU result), commits it to a 32 x 64-bit integer register file, and serves the two ID-stage read ports with same-cycle write-through bypass. Also keeps a retirement counter and a registered last-write record for debug and trace.

## Interface
Parameters:
- XLEN, 64, datapath width
- NREGS, 32, architectural register count; address width is clog2(NREGS) = 5
- CNT_W, 32, retirement counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- mem_wb_read_data  in  XLEN  load data from MEM/WB
- mem_wb_result  in  XLEN  ALU result from MEM/WB
- mem_wb_rd  in  5  destination register
- mem_wb_memtoreg  in  1  1 = write load data, 0 = write ALU result
- mem_wb_regwrite  in  1  write enable
- rs1_addr, rs2_addr  in  5 each  ID-stage read addresses
- rs1_data, rs2_data  out  XLEN each  read data, combinational
- wb_data  out  XLEN  selected writeback value, combinational
- wb_we  out  1  effective write this cycle, combinational
- retire_count  out  CNT_W  number of committed writes
- last_valid  out  1  a write has committed since reset
- last_rd  out  5  rd of most recent committed write
- last_data  out  XLEN  data of most recent committed write

## Operation
- wb_data = mem_wb_memtoreg ? mem_wb_read_data : mem_wb_result.
- wb_we = mem_wb_regwrite && (mem_wb_rd != 0) && !reset.
- On a clock edge with wb_we set: regs[mem_wb_rd] <= wb_data; retire_count increments; last_rd <= mem_wb_rd, last_data <= wb_data, last_valid <= 1.
- x0: reads always return 0; writes to rd=0 are dropped, do not count, and do not update last_*.
- Read port n: if addr == 0 -> 0; else if wb_we && addr == mem_wb_rd -> wb_data (bypass); else regs[addr]. Both ports bypass independently; rs1_addr == rs2_addr is legal and yields identical data.
- retire_count wraps from 2^CNT_W-1 to 0 with no flag.
- mem_wb_regwrite=0: no state change regardless of other inputs.

## Timing
- Reset (sampled at edge): regs x1..x31 <= 0, retire_count <= 0, last_valid <= 0, last_rd <= 0, last_data <= 0. Completes in one cycle.
- Write presented in a reset-asserted cycle is discarded (wb_we forced 0); the reset cycle's read ports return 0 for every address.
- Read latency 0 (combinational); write latency 1 edge; bypass makes a write visible on read ports in the same cycle it is presented.
- No handshake; one write per cycle max; no stall input (upstream holds MEM/WB by bubbling regwrite=0).
- No combinational path from read ports to state; wb_data/wb_we/rs*_data depend only on current inputs and regs.

## Structure
- Shared pipeline package: XLEN, NREGS, REG_ADDR_W = 5, and the reg-index type; MEM/WB field widths taken from the same package.
- Sub-module regfile_2r1w (storage + x0 + bypass) natural; top handles writeback mux, counter, last-write record.

## Test plan
- Reset then read x1..x31 on both ports -> all 0; retire_count=0, last_valid=0.
- regwrite=1, rd=5, memtoreg=0, result=0xDEADBEEF_00000001, rs1_addr=5 same cycle -> rs1_data=0xDEADBEEF_00000001 via bypass; next cycle still same from storage; retire_count=1, last_rd=5.
- memtoreg=1, read_data=0x1234, result=0xFFFF, rd=7 -> x7=0x1234.
- Write rd=0 with result=0xFF, regwrite=1 -> rs1_addr=0 reads 0; retire_count and last_* unchanged.
- Write rd=9 data 0xAA while reset=1 -> x9 stays 0, retire_count=0; write rd=9 data 0xBB after reset deasserted -> x9=0xBB.
- Preload retire_count near wrap (CNT_W=4 build): 16 commits from reset -> retire_count=0; rs1_addr=rs2_addr=3 with bypass write to x3 -> both ports equal wb_data.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants and MEM/WB field types
// used by the writeback stage and its register file.
package wb_regfile_pkg;

    localparam int XLEN       = 64;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = $clog2(NREGS);
    localparam int CNT_W      = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    typedef struct packed {
        logic [XLEN-1:0] read_data;
        logic [XLEN-1:0] result;
        reg_idx_t        rd;
        logic            memtoreg;
        logic            regwrite;
    } mem_wb_t;

endpackage

// File: rtl/wb_regfile_2r1w.sv
// Two-read one-write integer register file with hardwired x0
// and same-cycle write-through bypass on both read ports.
module wb_regfile_2r1w
    import wb_regfile_pkg::*;
#(
    parameter int DW    = wb_regfile_pkg::XLEN,
    parameter int NR    = wb_regfile_pkg::NREGS,
    parameter int AW    = $clog2(NR)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr1_i,
    input  logic [AW-1:0] raddr2_i,
    output logic [DW-1:0] rdata1_o,
    output logic [DW-1:0] rdata2_o
);

    logic [DW-1:0] regs_q [NR];

    // Entry 0 is cleared by reset and never written, so it stays zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NR; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = regs_q[raddr1_i];
        if (reset || raddr1_i == '0) begin
            rdata1_o = '0;
        end else if (we_i && raddr1_i == waddr_i) begin
            rdata1_o = wdata_i;
        end
    end

    always_comb begin
        rdata2_o = regs_q[raddr2_i];
        if (reset || raddr2_i == '0) begin
            rdata2_o = '0;
        end else if (we_i && raddr2_i == waddr_i) begin
            rdata2_o = wdata_i;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects writeback data, commits it to the
// register file, and tracks retirement count and last write.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int XLEN  = wb_regfile_pkg::XLEN,
    parameter int NREGS = wb_regfile_pkg::NREGS,
    parameter int CNT_W = wb_regfile_pkg::CNT_W,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  mem_wb_read_data,
    input  logic [XLEN-1:0]  mem_wb_result,
    input  logic [AW-1:0]    mem_wb_rd,
    input  logic             mem_wb_memtoreg,
    input  logic             mem_wb_regwrite,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic [XLEN-1:0]  wb_data,
    output logic             wb_we,
    output logic [CNT_W-1:0] retire_count,
    output logic             last_valid,
    output logic [AW-1:0]    last_rd,
    output logic [XLEN-1:0]  last_data
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lv_q, lv_d;
    logic [AW-1:0]    lrd_q, lrd_d;
    logic [XLEN-1:0]  ld_q, ld_d;

    assign wb_data = mem_wb_memtoreg ? mem_wb_read_data : mem_wb_result;
    assign wb_we   = mem_wb_regwrite && (mem_wb_rd != '0) && !reset;

    wb_regfile_2r1w #(
        .DW (XLEN),
        .NR (NREGS),
        .AW (AW)
    ) u_rf (
        .clk      (clk),
        .reset    (reset),
        .we_i     (wb_we),
        .waddr_i  (mem_wb_rd),
        .wdata_i  (wb_data),
        .raddr1_i (rs1_addr),
        .raddr2_i (rs2_addr),
        .rdata1_o (rs1_data),
        .rdata2_o (rs2_data)
    );

    // Counter wraps silently; x0 writes never reach here via wb_we.
    always_comb begin
        cnt_d = cnt_q;
        lv_d  = lv_q;
        lrd_d = lrd_q;
        ld_d  = ld_q;
        if (wb_we) begin
            cnt_d = cnt_q + 1'b1;
            lv_d  = 1'b1;
            lrd_d = mem_wb_rd;
            ld_d  = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            lv_q  <= 1'b0;
            lrd_q <= '0;
            ld_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            lv_q  <= lv_d;
            lrd_q <= lrd_d;
            ld_q  <= ld_d;
        end
    end

    assign retire_count = cnt_q;
    assign last_valid   = lv_q;
    assign last_rd      = lrd_q;
    assign last_data    = ld_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile built with a 4-bit retire counter
// so the wrap can be reached in a few commits.
module tb_wb_regfile;

    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic [63:0]   mem_wb_read_data;
    logic [63:0]   mem_wb_result;
    logic [4:0]    mem_wb_rd;
    logic          mem_wb_memtoreg;
    logic          mem_wb_regwrite;
    logic [4:0]    rs1_addr;
    logic [4:0]    rs2_addr;
    logic [63:0]   rs1_data;
    logic [63:0]   rs2_data;
    logic [63:0]   wb_data;
    logic          wb_we;
    logic [CW-1:0] retire_count;
    logic          last_valid;
    logic [4:0]    last_rd;
    logic [63:0]   last_data;

    wb_regfile #(
        .CNT_W (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .mem_wb_read_data (mem_wb_read_data),
        .mem_wb_result    (mem_wb_result),
        .mem_wb_rd        (mem_wb_rd),
        .mem_wb_memtoreg  (mem_wb_memtoreg),
        .mem_wb_regwrite  (mem_wb_regwrite),
        .rs1_addr         (rs1_addr),
        .rs2_addr         (rs2_addr),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .wb_data          (wb_data),
        .wb_we            (wb_we),
        .retire_count     (retire_count),
        .last_valid       (last_valid),
        .last_rd          (last_rd),
        .last_data        (last_data)
    );

    typedef struct {
        string         tag;
        logic [63:0]   rs1;
        logic [63:0]   rs2;
        logic [63:0]   wbd;
        logic          we;
        logic [CW-1:0] cnt;
        logic          lv;
        logic [4:0]    lrd;
        logic [63:0]   ld;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0]   m_regs [32];
    logic [CW-1:0] m_cnt;
    logic          m_lv;
    logic [4:0]    m_lrd;
    logic [63:0]   m_ld;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, ".rs1"}, rs1_data, e.rs1);
            check({e.tag, ".rs2"}, rs2_data, e.rs2);
            check({e.tag, ".wbd"}, wb_data, e.wbd);
            check({e.tag, ".we"}, {63'd0, wb_we}, {63'd0, e.we});
            check({e.tag, ".cnt"}, {60'd0, retire_count}, {60'd0, e.cnt});
            check({e.tag, ".lv"}, {63'd0, last_valid}, {63'd0, e.lv});
            check({e.tag, ".lrd"}, {59'd0, last_rd}, {59'd0, e.lrd});
            check({e.tag, ".ld"}, last_data, e.ld);
        end
    end

    function automatic logic [63:0] exp_read(input logic [4:0] a,
            input logic rst, input logic we, input logic [4:0] rd,
            input logic [63:0] wd);
        if (rst || a == 5'd0) return 64'd0;
        if (we && a == rd) return wd;
        return m_regs[a];
    endfunction

    task automatic drive(input string tag, input logic rst,
            input logic rw, input logic m2r, input logic [4:0] rd,
            input logic [63:0] rdat, input logic [63:0] res,
            input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        logic [63:0] wd;
        logic we;
        reset            = rst;
        mem_wb_regwrite  = rw;
        mem_wb_memtoreg  = m2r;
        mem_wb_rd        = rd;
        mem_wb_read_data = rdat;
        mem_wb_result    = res;
        rs1_addr         = a1;
        rs2_addr         = a2;
        wd    = m2r ? rdat : res;
        we    = rw && rd != 5'd0 && !rst;
        e.tag = tag;
        e.rs1 = exp_read(a1, rst, we, rd, wd);
        e.rs2 = exp_read(a2, rst, we, rd, wd);
        e.wbd = wd;
        e.we  = we;
        e.cnt = m_cnt;
        e.lv  = m_lv;
        e.lrd = m_lrd;
        e.ld  = m_ld;
        sb.push_back(e);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
            m_cnt = '0;
            m_lv  = 1'b0;
            m_lrd = 5'd0;
            m_ld  = 64'd0;
        end else if (we) begin
            m_regs[rd] = wd;
            m_cnt = m_cnt + 1'b1;
            m_lv  = 1'b1;
            m_lrd = rd;
            m_ld  = wd;
        end
        #1;
    endtask

    task automatic rd_only(input string tag, input logic [4:0] a1,
                           input logic [4:0] a2);
        drive(tag, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, a1, a2);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
        m_cnt = '0;
        m_lv  = 1'b0;
        m_lrd = 5'd0;
        m_ld  = 64'd0;
        reset = 1'b1;
        mem_wb_regwrite  = 1'b0;
        mem_wb_memtoreg  = 1'b0;
        mem_wb_rd        = 5'd0;
        mem_wb_read_data = 64'd0;
        mem_wb_result    = 64'd0;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        @(posedge clk);
        #1;

        drive("rst0", 1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd1, 5'd2);
        drive("rst_wr9", 1'b1, 1'b1, 1'b0, 5'd9, 64'd0, 64'hAA,
              5'd9, 5'd9);
        for (int a = 1; a < 32; a++) begin
            rd_only("rst_rd", 5'(a), 5'(32 - a));
        end

        drive("byp5", 1'b0, 1'b1, 1'b0, 5'd5, 64'h0,
              64'hDEADBEEF_00000001, 5'd5, 5'd4);
        rd_only("hold5", 5'd5, 5'd5);
        drive("ld7", 1'b0, 1'b1, 1'b1, 5'd7, 64'h1234, 64'hFFFF,
              5'd1, 5'd7);
        rd_only("rd7", 5'd7, 5'd5);
        drive("x0wr", 1'b0, 1'b1, 1'b0, 5'd0, 64'h0, 64'hFF,
              5'd0, 5'd0);
        rd_only("x0rd", 5'd0, 5'd7);
        drive("wr9", 1'b0, 1'b1, 1'b0, 5'd9, 64'h0, 64'hBB, 5'd8, 5'd9);
        rd_only("rd9", 5'd9, 5'd5);
        drive("norw", 1'b0, 1'b0, 1'b1, 5'd9, 64'h77, 64'h66,
              5'd9, 5'd9);
        drive("same3", 1'b0, 1'b1, 1'b0, 5'd3, 64'h0, 64'h3333_5555,
              5'd3, 5'd3);
        rd_only("rd3", 5'd3, 5'd3);

        drive("rst1", 1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd3, 5'd9);
        for (int i = 0; i < 16; i++) begin
            drive("wrap", 1'b0, 1'b1, i[0], 5'($urandom_range(1, 31)),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        rd_only("wrap0", 5'd1, 5'd2);

        for (int i = 0; i < 60; i++) begin
            drive("rand", 1'b0, 1'($urandom_range(0, 3) != 0),
                  1'($urandom), 5'($urandom_range(0, 31)),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        @(negedge clk);
        #1;
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
